// File: rtl/spmv_result_packer.sv
// Packs one precision-converted scalar per cycle (double/single/half) into 256-bit
// write-back beats with a byte keep mask; flush closes a vector with a last beat.
module spmv_result_packer #(
    parameter int OUT_W = 256
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic [1:0]         Ctrl_sig,
    input  logic               flush,
    input  logic               in_double_valid,
    output logic               in_double_ready,
    input  logic [63:0]        in_double_data,
    input  logic               in_single_valid,
    output logic               in_single_ready,
    input  logic [31:0]        in_single_data,
    input  logic               in_half_valid,
    output logic               in_half_ready,
    input  logic [15:0]        in_half_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [OUT_W-1:0]   out_data,
    output logic [OUT_W/8-1:0] out_keep,
    output logic               out_last,
    output logic               flush_done
);
    localparam int KEEP_W   = OUT_W / 8;
    localparam int D_LANES  = OUT_W / 64;
    localparam int S_LANES  = OUT_W / 32;
    localparam int H_LANES  = OUT_W / 16;
    localparam int CNT_W    = $clog2(H_LANES);
    localparam logic [1:0] M_HALF = 2'd0, M_SINGLE = 2'd1, M_DOUBLE = 2'd2;

    logic [1:0]       mode_q;
    logic [CNT_W-1:0] cnt;
    logic [OUT_W-1:0] asm_buf;
    logic             flush_pend;

    logic [1:0]        cur_mode;
    logic [CNT_W-1:0]  last_idx;
    logic              sel_valid, sel_ready, out_free;
    logic              accept, last_lane, flush_req;
    logic [OUT_W-1:0]  next_word;
    logic [KEEP_W-1:0] keep_part;
    int                lane_bytes, nbytes;

    // A word in progress keeps the mode it started with; Ctrl_sig only matters at cnt==0.
    always_comb begin
        cur_mode  = (cnt == '0) ? Ctrl_sig : mode_q;
        last_idx  = '0;
        sel_valid = 1'b0;
        case (cur_mode)
            M_DOUBLE: begin last_idx = CNT_W'(D_LANES - 1); sel_valid = in_double_valid; end
            M_SINGLE: begin last_idx = CNT_W'(S_LANES - 1); sel_valid = in_single_valid; end
            M_HALF:   begin last_idx = CNT_W'(H_LANES - 1); sel_valid = in_half_valid;   end
            default:  begin last_idx = '0; sel_valid = 1'b0; end
        endcase
        out_free  = !out_valid || out_ready;
        sel_ready = (cur_mode != 2'd3) && !flush_pend && ((cnt != last_idx) || out_free);
        in_double_ready = sel_ready && (cur_mode == M_DOUBLE);
        in_single_ready = sel_ready && (cur_mode == M_SINGLE);
        in_half_ready   = sel_ready && (cur_mode == M_HALF);
        accept    = sel_valid && sel_ready;
        last_lane = accept && (cnt == last_idx);
        flush_req = flush && !flush_pend;
    end

    always_comb begin
        next_word = asm_buf;
        case (cur_mode)
            M_DOUBLE:
                for (int i = 0; i < D_LANES; i++)
                    if (cnt == CNT_W'(i)) next_word[i*64 +: 64] = in_double_data;
            M_SINGLE:
                for (int i = 0; i < S_LANES; i++)
                    if (cnt == CNT_W'(i)) next_word[i*32 +: 32] = in_single_data;
            M_HALF:
                for (int i = 0; i < H_LANES; i++)
                    if (cnt == CNT_W'(i)) next_word[i*16 +: 16] = in_half_data;
            default: next_word = asm_buf;
        endcase
    end

    // Partial beats only exist with cnt>0, so the latched mode sets the lane width.
    always_comb begin
        case (mode_q)
            M_DOUBLE: lane_bytes = 8;
            M_SINGLE: lane_bytes = 4;
            default:  lane_bytes = 2;
        endcase
        nbytes    = int'(cnt) * lane_bytes;
        keep_part = '0;
        for (int b = 0; b < KEEP_W; b++)
            keep_part[b] = (b < nbytes);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            mode_q     <= M_DOUBLE;
            cnt        <= '0;
            asm_buf    <= '0;
            flush_pend <= 1'b0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_keep   <= '0;
            out_last   <= 1'b0;
            flush_done <= 1'b0;
        end else begin
            flush_done <= 1'b0;
            if (accept && cnt == '0) mode_q <= Ctrl_sig;
            if (out_valid && out_ready) out_valid <= 1'b0;

            if (last_lane) begin
                // A flush landing on the completing element rides on this full beat.
                out_valid  <= 1'b1;
                out_data   <= next_word;
                out_keep   <= '1;
                out_last   <= flush_req;
                cnt        <= '0;
                asm_buf    <= '0;
                flush_done <= flush_req;
            end else if (flush_pend && out_free) begin
                if (cnt != '0) begin
                    out_valid <= 1'b1;
                    out_data  <= asm_buf;
                    out_keep  <= keep_part;
                    out_last  <= 1'b1;
                end
                cnt        <= '0;
                asm_buf    <= '0;
                flush_pend <= 1'b0;
                flush_done <= 1'b1;
            end else begin
                if (accept) begin
                    asm_buf <= next_word;
                    cnt     <= cnt + 1'b1;
                end
                if (flush_req) flush_pend <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_spmv_result_packer.sv
// Scoreboard bench: a stream-level model gathers accepted scalars into expected beats;
// a negedge monitor checks readies, held output stability and every emitted beat.
module tb_spmv_result_packer;
    logic         clk = 1'b0, rstn = 1'b0;
    logic [1:0]   Ctrl_sig = 2'd2;
    logic         flush = 1'b0;
    logic         in_double_valid = 1'b0, in_single_valid = 1'b0, in_half_valid = 1'b0;
    logic         in_double_ready, in_single_ready, in_half_ready;
    logic [63:0]  in_double_data = '0;
    logic [31:0]  in_single_data = '0;
    logic [15:0]  in_half_data = '0;
    logic         out_valid, out_ready = 1'b1, out_last, flush_done;
    logic [255:0] out_data;
    logic [31:0]  out_keep;

    spmv_result_packer dut (
        .clk(clk), .rstn(rstn), .Ctrl_sig(Ctrl_sig), .flush(flush),
        .in_double_valid(in_double_valid), .in_double_ready(in_double_ready), .in_double_data(in_double_data),
        .in_single_valid(in_single_valid), .in_single_ready(in_single_ready), .in_single_data(in_single_data),
        .in_half_valid(in_half_valid), .in_half_ready(in_half_ready), .in_half_data(in_half_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_keep(out_keep),
        .out_last(out_last), .flush_done(flush_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [255:0] d;
        logic [31:0]  k;
        logic         l;
    } beat_t;

    beat_t        exp_q[$];
    logic [63:0]  elems[$];
    logic [1:0]   mode_m = 2'd2;
    bit           pend_m = 0, prev_hold = 0;
    logic [255:0] prev_d;
    logic [31:0]  prev_k;
    logic         prev_l;
    int           fd_seen = 0, fd_exp = 0;
    int           checks = 0, errors = 0;

    task automatic chk(input string nm, input logic [299:0] act, input logic [299:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    function automatic int lw(input logic [1:0] m);
        case (m)
            2'd2: return 64;
            2'd1: return 32;
            2'd0: return 16;
            default: return 0;
        endcase
    endfunction

    // Lane i of a beat holds the i-th accepted scalar; keep covers exactly those bytes.
    function automatic beat_t mk_beat(input logic [1:0] m, input bit last);
        beat_t b;
        int w, nb;
        w = lw(m);
        b.d = '0;
        foreach (elems[i]) b.d = b.d | ({192'b0, elems[i]} << (i * w));
        nb = elems.size() * w / 8;
        b.k = (nb >= 32) ? 32'hFFFF_FFFF : 32'((64'd1 << nb) - 64'd1);
        b.l = last;
        return b;
    endfunction

    always @(negedge clk) begin : monitor
        logic [1:0]  eff;
        int          lanes;
        bit          er, acc, just_full;
        logic [63:0] e;
        beat_t       b;
        if (!rstn) begin
            exp_q.delete();
            elems.delete();
            pend_m    = 0;
            prev_hold = 0;
            fd_exp    = fd_seen;
        end else begin
            if (flush_done) begin
                fd_seen++;
                pend_m = 0;
            end
            eff   = (elems.size() == 0) ? Ctrl_sig : mode_m;
            lanes = (eff == 2'd3) ? 0 : 256 / lw(eff);
            er = !pend_m && eff != 2'd3 && (elems.size() != lanes - 1 || !out_valid || out_ready);
            chk("readies", {in_double_ready, in_single_ready, in_half_ready},
                {er && eff == 2'd2, er && eff == 2'd1, er && eff == 2'd0});

            if (prev_hold) begin
                chk("hold_valid", out_valid, 1'b1);
                chk("hold_beat", {out_data, out_keep, out_last}, {prev_d, prev_k, prev_l});
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL extra_beat actual=%0h expected=none t=%0t", out_data, $time);
                end else begin
                    b = exp_q.pop_front();
                    chk("beat_data", out_data, b.d);
                    chk("beat_keep", out_keep, b.k);
                    chk("beat_last", out_last, b.l);
                end
            end
            prev_hold = out_valid && !out_ready;
            prev_d = out_data;
            prev_k = out_keep;
            prev_l = out_last;

            just_full = 0;
            acc = 0;
            e = '0;
            case (eff)
                2'd2: begin acc = in_double_valid && in_double_ready; e = in_double_data; end
                2'd1: begin acc = in_single_valid && in_single_ready; e = {32'b0, in_single_data}; end
                2'd0: begin acc = in_half_valid && in_half_ready; e = {48'b0, in_half_data}; end
                default: acc = 0;
            endcase
            if (acc) begin
                if (elems.size() == 0) mode_m = eff;
                elems.push_back(e);
                if (elems.size() == lanes) begin
                    exp_q.push_back(mk_beat(mode_m, 0));
                    elems.delete();
                    just_full = 1;
                end
            end
            if (flush && !pend_m) begin
                fd_exp++;
                if (just_full) begin
                    b = exp_q.pop_back();
                    b.l = 1'b1;
                    exp_q.push_back(b);
                end else begin
                    if (elems.size() > 0) exp_q.push_back(mk_beat(mode_m, 1));
                    elems.delete();
                    pend_m = 1;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_valid(input logic [1:0] m, input logic v, input logic [63:0] d);
        case (m)
            2'd2: begin in_double_valid = v; in_double_data = d; end
            2'd1: begin in_single_valid = v; in_single_data = d[31:0]; end
            default: begin in_half_valid = v; in_half_data = d[15:0]; end
        endcase
    endtask

    task automatic push(input logic [1:0] m, input logic [63:0] d);
        bit got = 0;
        set_valid(m, 1'b1, d);
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if ((m == 2'd2 && in_double_ready) || (m == 2'd1 && in_single_ready) ||
                (m == 2'd0 && in_half_ready)) begin
                got = 1;
                break;
            end
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL push_timeout actual=no_ready expected=ready mode=%0d", m);
        end
        tick();
        set_valid(m, 1'b0, d);
    endtask

    task automatic wait_flush();
        bit ok = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            #1;
            if (fd_seen == fd_exp) begin
                ok = 1;
                break;
            end
        end
        chk("flush_done_count", 32'(fd_seen), 32'(fd_exp));
        if (!ok) $display("FAIL flush_timeout actual=%0d expected=%0d", fd_seen, fd_exp);
        tick();
    endtask

    task automatic do_flush(input bit dbl);
        flush = 1'b1;
        tick();
        if (dbl) tick();
        flush = 1'b0;
        wait_flush();
    endtask

    task automatic drain();
        bit ok = 0;
        in_double_valid = 0;
        in_single_valid = 0;
        in_half_valid   = 0;
        out_ready       = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            #1;
            if (exp_q.size() == 0 && !out_valid) begin
                ok = 1;
                break;
            end
        end
        chk("drain_empty", {ok, 32'(exp_q.size())}, {1'b1, 32'd0});
        tick();
    endtask

    task automatic rand_cycle();
        if ($urandom_range(0, 7) == 0)
            Ctrl_sig = ($urandom_range(0, 15) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
        in_double_valid = 1'($urandom);
        in_single_valid = 1'($urandom);
        in_half_valid   = 1'($urandom);
        in_double_data  = {$urandom, $urandom};
        in_single_data  = $urandom;
        in_half_data    = 16'($urandom);
        out_ready       = ($urandom_range(0, 3) != 0);
        tick();
    endtask

    initial begin
        #1;
        chk("reset_outputs", {out_valid, out_data, out_keep, out_last, flush_done}, '0);
        tick();
        tick();
        rstn = 1'b1;
        tick();

        // Four doubles back-to-back form one full beat a cycle after the fourth.
        Ctrl_sig = 2'd2;
        for (int i = 1; i <= 4; i++) push(2'd2, 64'(i));
        chk("t1_latency_valid", out_valid, 1'b1);
        chk("t1_data", out_data, {64'd4, 64'd3, 64'd2, 64'd1});
        chk("t1_keep_last", {out_keep, out_last}, {32'hFFFF_FFFF, 1'b0});
        drain();

        // 32 halves with the sink stalled: the 32nd waits until the first beat drains.
        Ctrl_sig  = 2'd0;
        out_ready = 1'b0;
        for (int i = 0; i < 31; i++) push(2'd0, 64'(16'h100 + i));
        set_valid(2'd0, 1'b1, 64'h1FF);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t2_half_ready_stall", in_half_ready, 1'b0);
        end
        tick();
        out_ready = 1'b1;
        push(2'd0, 64'h1FF);
        drain();

        // Three singles then flush: a partial last beat.
        Ctrl_sig = 2'd1;
        for (int i = 0; i < 3; i++) push(2'd1, 64'($urandom));
        do_flush(0);
        drain();

        // Idle flush: no beat, readies back once the flush completes.
        Ctrl_sig = 2'd2;
        do_flush(0);
        @(negedge clk);
        chk("t4_ready_back", in_double_ready, 1'b1);
        tick();

        // Flush coincident with the fourth double: one full last beat, nothing more.
        for (int i = 0; i < 3; i++) push(2'd2, {$urandom, $urandom});
        set_valid(2'd2, 1'b1, 64'hDEAD_BEEF_0000_0004);
        flush = 1'b1;
        tick();
        set_valid(2'd2, 1'b0, '0);
        flush = 1'b0;
        wait_flush();
        drain();

        // Reset mid-operation discards a pending beat and a partial word.
        Ctrl_sig  = 2'd1;
        out_ready = 1'b0;
        for (int i = 0; i < 10; i++) push(2'd1, 64'(32'hA000 + i));
        rstn = 1'b0;
        #1;
        chk("t6_reset_valid", out_valid, 1'b0);
        tick();
        tick();
        rstn = 1'b1;
        tick();
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) push(2'd1, 64'(32'hB000 + i));
        drain();

        // Randomized traffic with mode changes and (sometimes repeated) flushes.
        for (int r = 0; r < 25; r++) begin
            Ctrl_sig = 2'($urandom_range(0, 2));
            for (int c = 0; c < int'($urandom_range(10, 50)); c++) rand_cycle();
            do_flush(1'($urandom));
        end
        drain();
        do_flush(0);
        drain();
        chk("final_flush_count", 32'(fd_seen), 32'(fd_exp));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
